// File: rtl/pdm_decimator.sv
// PDM microphone front end: generates the microphone clock, samples the PDM bitstream once per
// m_clk period and reports the count of ones per WINDOW samples. Optional macro: PDM_PEAK_HOLD_EN.
module pdm_decimator #(
    parameter int CLK_FREQ  = 100,
    parameter int MCLK_FREQ = 2500,
    parameter int WINDOW    = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    output logic                         m_clk,
    output logic                         m_lr_sel,
    input  logic                         m_data,
`ifdef PDM_PEAK_HOLD_EN
    input  logic                         peak_clr,
    output logic [$clog2(WINDOW+1)-1:0]  peak,
`endif
    output logic [$clog2(WINDOW+1)-1:0]  amplitude,
    output logic                         amplitude_valid
);

    localparam int CLK_DIV = (CLK_FREQ * 1000) / (2 * MCLK_FREQ);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AMP_W   = $clog2(WINDOW + 1);
    localparam int BIT_W   = $clog2(WINDOW);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WINDOW - 1);

    logic [DIV_W-1:0] div_q,   div_d;
    logic             mclk_q,  mclk_d;
    logic [AMP_W-1:0] ones_q,  ones_d;
    logic [BIT_W-1:0] bit_q,   bit_d;
    logic [AMP_W-1:0] amp_q,   amp_d;
    logic             valid_q, valid_d;

    logic             div_wrap;
    logic             sample;
    logic             window_done;
    logic [AMP_W-1:0] ones_sum;

    // A sample is taken on the edge that registers m_clk 0->1, so m_data is stable around it.
    assign div_wrap    = (div_q == DIV_LAST);
    assign sample      = en && div_wrap && !mclk_q;
    assign window_done = sample && (bit_q == BIT_LAST);
    assign ones_sum    = ones_q + AMP_W'(m_data);

    always_comb begin
        div_d   = div_q;
        mclk_d  = mclk_q;
        ones_d  = ones_q;
        bit_d   = bit_q;
        amp_d   = amp_q;
        valid_d = 1'b0;

        if (!en) begin
            // Disabled: park the divider and drop any partial window; amplitude keeps its value.
            div_d  = '0;
            mclk_d = 1'b0;
            ones_d = '0;
            bit_d  = '0;
        end else begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
            if (div_wrap) begin
                mclk_d = ~mclk_q;
            end
            if (sample) begin
                if (window_done) begin
                    amp_d   = ones_sum;
                    valid_d = 1'b1;
                    ones_d  = '0;
                    bit_d   = '0;
                end else begin
                    ones_d = ones_sum;
                    bit_d  = bit_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            mclk_q  <= 1'b0;
            ones_q  <= '0;
            bit_q   <= '0;
            amp_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            mclk_q  <= mclk_d;
            ones_q  <= ones_d;
            bit_q   <= bit_d;
            amp_q   <= amp_d;
            valid_q <= valid_d;
        end
    end

`ifdef PDM_PEAK_HOLD_EN
    logic [AMP_W-1:0] peak_q, peak_d;

    // Peak follows the amplitude register edge-for-edge; a clear coinciding with a new
    // window restarts the peak from that window rather than from zero.
    always_comb begin
        peak_d = peak_q;
        if (peak_clr && window_done) begin
            peak_d = ones_sum;
        end else if (peak_clr) begin
            peak_d = '0;
        end else if (window_done && (ones_sum > peak_q)) begin
            peak_d = ones_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif

    assign m_clk           = mclk_q;
    assign m_lr_sel        = 1'b0;
    assign amplitude       = amp_q;
    assign amplitude_valid = valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: drives PDM windows in step with m_clk and scores each
// amplitude_valid against counts computed from the driven bits.
module tb_pdm_decimator;

    localparam int CLK_FREQ  = 100;
    localparam int MCLK_FREQ = 2500;
    localparam int WINDOW    = 128;
    localparam int CLK_DIV   = 20;                          // 100 MHz / (2 * 2.5 MHz)
    localparam int MCLK_PER  = 2 * CLK_DIV;                 // 40 clk
    localparam int WIN_CLK   = WINDOW * MCLK_PER;           // 5120 clk between updates
    localparam int LAST_LAT  = (WINDOW - 1) * MCLK_PER;     // first sampling edge to valid
    localparam int AW        = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          m_clk;
    logic          m_lr_sel;
    logic          m_data;
    logic [AW-1:0] amplitude;
    logic          amplitude_valid;
`ifdef PDM_PEAK_HOLD_EN
    logic          peak_clr;
    logic [AW-1:0] peak;
`endif

    pdm_decimator #(
        .CLK_FREQ (CLK_FREQ),
        .MCLK_FREQ(MCLK_FREQ),
        .WINDOW   (WINDOW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .m_clk          (m_clk),
        .m_lr_sel       (m_lr_sel),
        .m_data         (m_data),
`ifdef PDM_PEAK_HOLD_EN
        .peak_clr       (peak_clr),
        .peak           (peak),
`endif
        .amplitude      (amplitude),
        .amplitude_valid(amplitude_valid)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    int            valid_cyc_q[$];
    logic          prev_valid = 1'b0;
    logic [AW-1:0] exp_amp;

    always @(negedge clk) begin
        if (amplitude_valid === 1'b1) begin
            valid_cyc_q.push_back(cyc);
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_valid: amplitude_valid high with no window pending, amplitude=%0d", amplitude);
            end else begin
                exp_amp = exp_q.pop_front();
                if (amplitude !== exp_amp) begin
                    tests_failed++;
                    $display("FAIL amplitude: got %0d expected %0d (cycle %0d)", amplitude, exp_amp, cyc);
                end
            end
            tests_run++;
            if (prev_valid) begin
                tests_failed++;
                $display("FAIL valid_width: amplitude_valid high on two consecutive cycles (got 2 expected 1)");
            end
        end
        prev_valid = (amplitude_valid === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_rise(output bit ok);
        int n = 0;
        while (m_clk === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (m_clk !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 200);
    endtask

    // mode: 0 zeros, 1 ones, 2 alternating 1/0, 3 random, 4 first n_ones ones then zeros
    task automatic drive_bits(input int mode, input int n_ones, input int nbits, input bit push,
                              output int first_rise);
        logic bits [WINDOW];
        int   ones = 0;
        bit   ok;
        first_rise = 0;
        for (int i = 0; i < WINDOW; i++) begin
            case (mode)
                0:       bits[i] = 1'b0;
                1:       bits[i] = 1'b1;
                2:       bits[i] = (i % 2 == 0);
                3:       bits[i] = 1'($urandom_range(0, 1));
                default: bits[i] = (i < n_ones);
            endcase
            if (i < nbits) ones += int'(bits[i]);
        end
        if (push) exp_q.push_back(AW'(ones));
        for (int i = 0; i < nbits; i++) begin
            m_data = bits[i];
            wait_rise(ok);
            if (!ok) begin
                tests_run++;
                tests_failed++;
                $display("FAIL mclk_timeout: no m_clk rise within 200 clk at bit %0d", i);
                return;
            end
            if (i == 0) first_rise = cyc;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d windows still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic fresh_start();
        @(negedge clk);
        en     = 1'b0;
        m_data = 1'b0;
        repeat (3) @(negedge clk);
        valid_cyc_q.delete();
        en = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst    = 1'b1;
        en     = 1'b1;
        m_data = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        tests_run++;
        if (m_clk !== 1'b0) begin tests_failed++; $display("FAIL reset_mclk: got %b expected 0", m_clk); end
        tests_run++;
        if (amplitude !== '0) begin tests_failed++; $display("FAIL reset_amplitude: got %0d expected 0", amplitude); end
        tests_run++;
        if (amplitude_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", amplitude_valid); end
        tests_run++;
        if (m_lr_sel !== 1'b0) begin tests_failed++; $display("FAIL lr_sel: got %b expected 0", m_lr_sel); end
`ifdef PDM_PEAK_HOLD_EN
        tests_run++;
        if (peak !== '0) begin tests_failed++; $display("FAIL reset_peak: got %0d expected 0", peak); end
`endif
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mclk_timing();
        int n = 0;
        int h = 0;
        int l = 0;
        fresh_start();
        while (m_clk !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        tests_run++;
        if (n != CLK_DIV) begin tests_failed++; $display("FAIL en_to_first_rise: got %0d clk expected %0d", n, CLK_DIV); end
        while (m_clk === 1'b1 && h < 100) begin @(negedge clk); h++; end
        tests_run++;
        if (h != CLK_DIV) begin tests_failed++; $display("FAIL mclk_high: got %0d clk expected %0d", h, CLK_DIV); end
        while (m_clk !== 1'b1 && l < 100) begin @(negedge clk); l++; end
        tests_run++;
        if (l != CLK_DIV) begin tests_failed++; $display("FAIL mclk_low: got %0d clk expected %0d", l, CLK_DIV); end
        en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (m_clk !== 1'b0) begin tests_failed++; $display("FAIL en_low_mclk: got %b expected 0", m_clk); end
    endtask

    task automatic test_all_ones();
        int fr;
        fresh_start();
        drive_bits(1, 0, WINDOW, 1'b1, fr);
        drive_bits(1, 0, WINDOW, 1'b1, fr);
        drain();
        tests_run++;
        if (valid_cyc_q.size() != 2) begin
            tests_failed++;
            $display("FAIL ones_valid_count: got %0d expected 2", valid_cyc_q.size());
        end else if (valid_cyc_q[1] - valid_cyc_q[0] != WIN_CLK) begin
            tests_failed++;
            $display("FAIL ones_valid_period: got %0d clk expected %0d", valid_cyc_q[1] - valid_cyc_q[0], WIN_CLK);
        end
        repeat (50) @(negedge clk);
        tests_run++;
        if (amplitude !== AW'(WINDOW) || amplitude_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL amplitude_hold: got %0d/%b expected %0d/0", amplitude, amplitude_valid, WINDOW);
        end
    endtask

    task automatic test_all_zeros();
        int fr;
        fresh_start();
        drive_bits(0, 0, WINDOW, 1'b1, fr);
        drain();
        tests_run++;
        if (valid_cyc_q.size() != 1 || valid_cyc_q[0] - fr != LAST_LAT) begin
            tests_failed++;
            $display("FAIL zeros_latency: got %0d valids, %0d clk expected 1, %0d clk",
                     valid_cyc_q.size(), (valid_cyc_q.size() > 0) ? valid_cyc_q[0] - fr : -1, LAST_LAT);
        end
    endtask

    task automatic test_alternating();
        int fr;
        fresh_start();
        drive_bits(2, 0, WINDOW, 1'b1, fr);
        drain();
    endtask

    task automatic test_back_to_back_random();
        int fr;
        fresh_start();
        drive_bits(3, 0, WINDOW, 1'b1, fr);
        drive_bits(3, 0, WINDOW, 1'b1, fr);
        drain();
        tests_run++;
        if (valid_cyc_q.size() != 2 || valid_cyc_q[1] - valid_cyc_q[0] != WIN_CLK) begin
            tests_failed++;
            $display("FAIL random_valid_period: got %0d valids expected 2 spaced %0d clk", valid_cyc_q.size(), WIN_CLK);
        end
    endtask

    task automatic test_rst_mid_window();
        int fr;
        fresh_start();
        drive_bits(1, 0, 50, 1'b0, fr);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (amplitude !== '0 || m_clk !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_clear: got amplitude %0d m_clk %b expected 0 0", amplitude, m_clk);
        end
        valid_cyc_q.delete();
        drive_bits(1, 0, WINDOW, 1'b1, fr);
        drain();
        tests_run++;
        if (valid_cyc_q.size() != 1 || valid_cyc_q[0] - fr != LAST_LAT) begin
            tests_failed++;
            $display("FAIL rst_window_latency: got %0d valids expected 1 at %0d clk after first rise",
                     valid_cyc_q.size(), LAST_LAT);
        end
    endtask

    task automatic test_en_low_mid_window();
        int fr;
        fresh_start();
        drive_bits(4, 100, WINDOW, 1'b1, fr);
        drain();
        drive_bits(1, 0, 50, 1'b0, fr);
        @(negedge clk);
        en = 1'b0;
        repeat (100) @(negedge clk);
        tests_run++;
        if (m_clk !== 1'b0 || amplitude !== AW'(100)) begin
            tests_failed++;
            $display("FAIL en_low_hold: got m_clk %b amplitude %0d expected 0 100", m_clk, amplitude);
        end
        en = 1'b1;
        drive_bits(2, 0, WINDOW, 1'b1, fr);
        drain();
    endtask

`ifdef PDM_PEAK_HOLD_EN
    task automatic test_peak_hold();
        int fr;
        int win [3] = '{100, 40, 90};
        for (int k = 0; k < 3; k++) begin
            fresh_start();
            drive_bits(4, win[k], WINDOW, 1'b1, fr);
            drain();
            tests_run++;
            if (peak !== AW'(100)) begin tests_failed++; $display("FAIL peak_max_%0d: got %0d expected 100", k, peak); end
        end
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        tests_run++;
        if (peak !== '0) begin tests_failed++; $display("FAIL peak_clr: got %0d expected 0", peak); end
        fresh_start();
        drive_bits(4, 70, WINDOW, 1'b1, fr);
        drain();
        tests_run++;
        if (peak !== AW'(70)) begin tests_failed++; $display("FAIL peak_after_clr: got %0d expected 70", peak); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        m_data = 1'b0;
`ifdef PDM_PEAK_HOLD_EN
        peak_clr = 1'b0;
`endif
        test_reset();
        test_mclk_timing();
        test_all_ones();
        test_all_zeros();
        test_alternating();
        test_back_to_back_random();
        test_rst_mid_window();
        test_en_low_mid_window();
`ifdef PDM_PEAK_HOLD_EN
        test_peak_hold();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation exceeded 95000 clk, got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
